row_fetch: RTL and testbench
============================

Name: row_fetch

Overview:
- Line-fill engine that sits directly upstream of the 2048x8 row buffer, driving its write port (port A).
- On each line-start pulse it copies one row of bytes from the shared memory bus into one half of the buffer.
- The buffer is ping-pong: the scan-out side reads the half selected by disp_bank while this block fills the other half.
- One memory read is outstanding at a time; one buffer write is issued per returned byte.

Parameters:
- ADDR_W, 20, width of the source memory byte address.
- MAX_LEN, 1024, maximum bytes per row (equals one buffer half); row_len above this is clamped.

Ports:
- clk  input  1  single clock for all logic and for the row buffer write port.
- reset  input  1  synchronous, active-high reset.
- line_start  input  1  one-cycle pulse: swap banks and start fetching the next row.
- row_addr  input  ADDR_W  source start address; latched on an accepted line_start.
- row_len  input  11  byte count, 0..2047; latched on an accepted line_start and clamped to MAX_LEN.
- mem_req  output  1  read request, held until acknowledged.
- mem_addr  output  ADDR_W  read address; stable while mem_req is high.
- mem_ack  input  1  request accepted in this cycle.
- mem_rvalid  input  1  read data valid; arrives at least 1 cycle after mem_ack.
- mem_rdata  input  8  read data.
- buf_ce  output  1  row buffer write enable (port A cea).
- buf_ad  output  11  row buffer write address: {fill_bank, index[9:0]}.
- buf_din  output  8  row buffer write data.
- disp_bank  output  1  half currently owned by scan-out; fill_bank = ~disp_bank.
- busy  output  1  fetch in progress.
- overrun  output  1  sticky: a line_start arrived while busy; cleared only by reset.

Behaviour:
- Reset: all outputs 0, disp_bank=0, FSM=IDLE, internal counters 0. Reset asserted mid-fetch aborts the fetch immediately; mem_req is 0 the next cycle.
- FSM states:
  - IDLE. Accepted line_start → toggle disp_bank; latch addr and len; index=0. If len==0 stay IDLE (bank still toggles), else go to REQ.
  - REQ. mem_req=1, mem_addr=current addr. When mem_ack=1 → WAIT, and mem_req=0 the next cycle.
  - WAIT. When mem_rvalid=1 → capture mem_rdata and go to WR.
  - WR. One cycle: buf_ce=1, buf_din=captured byte, buf_ad={~disp_bank, index[9:0]}. Then increment addr (mod 2^ADDR_W) and index. If index was len-1 → IDLE, else → REQ.
- Timing:
  - line_start at cycle t → mem_req=1 at t+1.
  - mem_rvalid at cycle r → buf_ce at r+1 and next mem_req at r+2.
- busy=1 in every state except IDLE; it falls the cycle after the final buf_ce.
- line_start while busy:
  - ignored: no bank toggle, no restart, latched len/addr unchanged;
  - overrun set to 1.
- line_start on the same cycle busy falls (FSM already back in IDLE) is accepted normally.
- mem_ack or mem_rvalid outside REQ/WAIT respectively: ignored, no write.
- Clamp: row_len>1024 is latched as 1024; index never exceeds 1023, so writes never cross into disp_bank's half.
- mem_addr wraps from 2^ADDR_W-1 to 0.
- buf_ce is never asserted for an address in the disp_bank half.

Test Plan:
- Basic fill: reset, then line_start with row_addr=0x01000, row_len=4; memory acks after 1 cycle, data after 2 cycles returning 0xA0..0xA3 → disp_bank=1; writes 0xA0..0xA3 to buf_ad 0x000..0x003; busy low afterwards; overrun=0.
- Ping-pong: second line_start with row_len=2 and data 0x55, 0x66 → disp_bank=0; writes land at buf_ad 0x400 and 0x401; the half-0 bytes from the first test are untouched.
- Overrun: line_start with row_len=8, then another line_start on the 3rd byte's WAIT → overrun=1 and stays 1; disp_bank toggles only once; all 8 bytes written; latched length unchanged.
- Edge lengths: row_len=0 → bank toggles, busy never asserts, no mem_req. row_len=1500 → exactly 1024 writes, last buf_ad index 0x3FF, no write to the other half.
- Address wrap and backpressure: row_addr=0xFFFFE, row_len=4, mem_ack delayed 5 cycles → mem_req held with stable mem_addr; addresses issued are 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Reset mid-fetch: assert reset during WAIT → next cycle mem_req=0, busy=0, disp_bank=0, overrun=0; a stray mem_rvalid afterwards produces no buf_ce.

Source files
------------

// File: rtl/row_fetch_if.sv
// Memory read bus and row-buffer write port driven by the row_fetch line-fill engine.
// master = row_fetch side, slave = memory/buffer side.
interface row_fetch_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;
  logic              buf_ce;
  logic [10:0]       buf_ad;
  logic [7:0]        buf_din;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rvalid,
    input  mem_rdata,
    output buf_ce,
    output buf_ad,
    output buf_din
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rvalid,
    output mem_rdata,
    input  buf_ce,
    input  buf_ad,
    input  buf_din
  );
endinterface

// File: rtl/row_fetch.sv
// Line-fill engine: on each line_start, swaps ping-pong banks and copies one row of bytes
// from the memory bus into the half of the row buffer not owned by scan-out.
module row_fetch #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] row_addr,
  input  logic [10:0]       row_len,
  row_fetch_if.master       bus,
  output logic              disp_bank,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StWr} state_e;

  localparam logic [10:0] MaxLen = 11'(MAX_LEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [10:0]       len_q, len_d;
  logic [10:0]       index_q, index_d;
  logic [7:0]        data_q, data_d;
  logic              disp_bank_q, disp_bank_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    index_d     = index_q;
    data_d      = data_q;
    disp_bank_d = disp_bank_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (line_start) begin
          disp_bank_d = ~disp_bank_q;
          addr_d      = row_addr;
          len_d       = (row_len > MaxLen) ? MaxLen : row_len;
          index_d     = '0;
          // A zero-length row still swaps banks but fetches nothing.
          if (row_len != 11'd0) state_d = StReq;
        end
      end
      StReq: begin
        if (bus.mem_ack) state_d = StWait;
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          data_d  = bus.mem_rdata;
          state_d = StWr;
        end
      end
      StWr: begin
        addr_d  = addr_q + ADDR_W'(1);
        index_d = index_q + 11'd1;
        state_d = (index_q == len_q - 11'd1) ? StIdle : StReq;
      end
      default: state_d = StIdle;
    endcase

    // A line_start during a fetch is dropped but remembered until reset.
    if (line_start && (state_q != StIdle)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      index_q     <= '0;
      data_q      <= '0;
      disp_bank_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      index_q     <= index_d;
      data_q      <= data_d;
      disp_bank_q <= disp_bank_d;
      overrun_q   <= overrun_d;
    end
  end

  // Clamp keeps index below MAX_LEN, so the fill half is selected by the bank bit alone.
  assign bus.mem_req  = (state_q == StReq);
  assign bus.mem_addr = addr_q;
  assign bus.buf_ce   = (state_q == StWr);
  assign bus.buf_ad   = bus.buf_ce ? {~disp_bank_q, index_q[9:0]} : 11'd0;
  assign bus.buf_din  = bus.buf_ce ? data_q : 8'd0;

  assign disp_bank = disp_bank_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_row_fetch.sv
// Bench for row_fetch: memory responder, row-level scoreboard model, directed row scenarios.
module tb_row_fetch;

  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_start;
  logic [AW-1:0] row_addr;
  logic [10:0]   row_len;
  logic          disp_bank;
  logic          busy;
  logic          overrun;

  row_fetch_if #(.ADDR_W(AW)) bus ();

  row_fetch #(.ADDR_W(AW), .MAX_LEN(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .row_addr   (row_addr),
    .row_len    (row_len),
    .bus        (bus),
    .disp_bank  (disp_bank),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: byte = base + step * (addr - origin), per scenario.
  logic [7:0]    pat_base = 8'h00;
  logic [7:0]    pat_step = 8'h01;
  logic [AW-1:0] pat_org  = '0;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    logic [AW-1:0] d;
    logic [15:0]   p;
    d = a - pat_org;
    p = pat_step * d[7:0];
    return pat_base + p[7:0];
  endfunction

  // Memory responder: ack after ack_dly cycles of mem_req, data rv_dly cycles after ack.
  int            ack_dly = 1;
  int            rv_dly  = 2;
  int            req_cyc = 0;
  int            rv_cnt  = 0;
  logic [AW-1:0] rv_addr;
  logic          stray_ack = 1'b0;
  logic          stray_rv  = 1'b0;
  logic [AW-1:0] acked[$];

  initial begin
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack    = stray_ack;
      bus.mem_rvalid = stray_rv;
      bus.mem_rdata  = 8'hEE;
      if (reset) begin
        req_cyc = 0;
        rv_cnt  = 0;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_byte(rv_addr);
        end
      end else if (bus.mem_req) begin
        if (req_cyc >= ack_dly) begin
          bus.mem_ack = 1'b1;
          rv_addr     = bus.mem_addr;
          acked.push_back(bus.mem_addr);
          rv_cnt      = rv_dly;
          req_cyc     = 0;
        end else begin
          req_cyc++;
        end
      end
    end
  end

  // Row-level model: a row is the clamped byte count, written in order to the fill half.
  logic          mon_en = 1'b0;
  logic          bank_m, ovr_m, busy_m;
  logic [AW-1:0] addr_m;
  int            len_m, idx_m;
  int            wr_total = 0;
  int            hi_total = 0;
  logic [10:0]   last_ad;
  logic [7:0]    shadow [2048];

  initial begin
    logic          wr_ok;
    logic          busy_pre;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      wr_ok = 1'b0;
      ea    = addr_m + AW'(idx_m);
      if (mon_en) begin
        check("busy", busy, busy_m);
        check("disp_bank", disp_bank, bank_m);
        check("overrun", overrun, ovr_m);
        if (bus.mem_req) begin
          check("req_only_when_busy", bus.mem_req, busy_m);
          check("mem_addr", bus.mem_addr, ea);
        end
        if (bus.buf_ce) begin
          if (!busy_m) begin
            check("write_when_idle", bus.buf_ce, busy_m);
          end else begin
            check("buf_ad", bus.buf_ad, {~bank_m, idx_m[9:0]});
            check("buf_din", bus.buf_din, mem_byte(ea));
            wr_ok = 1'b1;
          end
          shadow[bus.buf_ad] = bus.buf_din;
          last_ad = bus.buf_ad;
          wr_total++;
          if (bus.buf_ad[10]) hi_total++;
        end
      end
      // Advance the model with the inputs the DUT samples at the coming edge.
      if (reset) begin
        bank_m = 1'b0; ovr_m = 1'b0; busy_m = 1'b0;
        addr_m = '0;   len_m = 0;    idx_m  = 0;
      end else begin
        busy_pre = busy_m;
        if (wr_ok) begin
          idx_m++;
          if (idx_m == len_m) busy_m = 1'b0;
        end
        if (line_start) begin
          if (busy_pre) begin
            ovr_m = 1'b1;
          end else begin
            bank_m = ~bank_m;
            addr_m = row_addr;
            len_m  = (row_len > 11'd1024) ? 1024 : int'(row_len);
            idx_m  = 0;
            busy_m = (len_m != 0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input logic [AW-1:0] a, input logic [10:0] l);
    row_addr   = a;
    row_len    = l;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("req_after_start", bus.mem_req, 1'b1);
  endtask

  task automatic wait_idle(output int cnt, input int limit);
    cnt = 0;
    while (busy && cnt < limit) begin
      cnt++;
      tick();
    end
    if (busy) check("idle_timeout", busy, 1'b0);
  endtask

  task automatic set_pat(input logic [7:0] b, input logic [7:0] s, input logic [AW-1:0] o);
    pat_base = b;
    pat_step = s;
    pat_org  = o;
  endtask

  initial begin
    int   cnt, w0, h0, n0;
    logic seen;
    reset      = 1'b1;
    line_start = 1'b0;
    row_addr   = '0;
    row_len    = '0;
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_buf_ce", bus.buf_ce, 1'b0);
    check("rst_buf_ad", bus.buf_ad, 11'h000);
    check("rst_mem_addr", bus.mem_addr, 20'h00000);
    check("rst_disp_bank", disp_bank, 1'b0);
    reset = 1'b0;
    tick();

    // Basic fill: 5 cycles per byte with ack after 1 and data 2 after ack.
    set_pat(8'hA0, 8'h01, 20'h01000);
    ack_dly = 1; rv_dly = 2;
    w0 = wr_total;
    start_row(20'h01000, 11'd4);
    wait_idle(cnt, 200);
    check("basic_busy_cycles", cnt, 20);
    check("basic_writes", wr_total - w0, 4);
    check("basic_byte0", shadow[0], 8'hA0);
    check("basic_byte3", shadow[3], 8'hA3);
    check("basic_last_ad", last_ad, 11'h003);
    check("basic_disp_bank", disp_bank, 1'b1);
    check("basic_overrun", overrun, 1'b0);
    tick();

    // Ping-pong into the upper half.
    set_pat(8'h55, 8'h11, 20'h02000);
    start_row(20'h02000, 11'd2);
    wait_idle(cnt, 200);
    check("pp_byte400", shadow[11'h400], 8'h55);
    check("pp_byte401", shadow[11'h401], 8'h66);
    check("pp_half0_kept", shadow[1], 8'hA1);
    check("pp_disp_bank", disp_bank, 1'b0);
    tick();

    // Overrun: second line_start during the third byte's wait.
    set_pat(8'h10, 8'h01, 20'h03000);
    w0 = wr_total;
    n0 = acked.size();
    start_row(20'h03000, 11'd8);
    cnt = 0;
    while (acked.size() < n0 + 3 && cnt < 100) begin
      cnt++;
      tick();
    end
    if (acked.size() < n0 + 3) check("ovr_ack_timeout", acked.size(), n0 + 3);
    row_addr   = 20'h12345;
    row_len    = 11'd3;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("ovr_set", overrun, 1'b1);
    wait_idle(cnt, 300);
    check("ovr_writes", wr_total - w0, 8);
    check("ovr_byte7", shadow[7], 8'h17);
    check("ovr_sticky", overrun, 1'b1);
    check("ovr_disp_bank", disp_bank, 1'b1);
    tick();

    // Zero length: bank toggles, nothing fetched.
    row_len    = 11'd0;
    row_addr   = 20'h0ABCD;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | busy | bus.mem_req;
      tick();
    end
    check("len0_no_activity", seen, 1'b0);
    check("len0_disp_bank", disp_bank, 1'b0);

    // Stray ack/rvalid while idle must not write.
    w0 = wr_total;
    stray_ack = 1'b1;
    stray_rv  = 1'b1;
    tick();
    stray_ack = 1'b0;
    stray_rv  = 1'b0;
    repeat (3) tick();
    check("idle_stray_writes", wr_total - w0, 0);

    // Clamp: 1500 requested, 1024 written to half 0 at 3 cycles per byte.
    set_pat(8'h00, 8'h03, 20'h40000);
    ack_dly = 0; rv_dly = 1;
    w0 = wr_total;
    h0 = hi_total;
    start_row(20'h40000, 11'd1500);
    wait_idle(cnt, 5000);
    check("clamp_writes", wr_total - w0, 1024);
    check("clamp_busy_cycles", cnt, 3072);
    check("clamp_last_ad", last_ad, 11'h3FF);
    check("clamp_no_hi_half", hi_total - h0, 0);
    check("clamp_disp_bank", disp_bank, 1'b1);
    tick();

    // Address wrap with slow acks.
    set_pat(8'h80, 8'h01, 20'hFFFFE);
    ack_dly = 5; rv_dly = 2;
    acked.delete();
    start_row(20'hFFFFE, 11'd4);
    wait_idle(cnt, 200);
    check("wrap_req_count", acked.size(), 4);
    if (acked.size() == 4) begin
      check("wrap_addr0", acked[0], 20'hFFFFE);
      check("wrap_addr1", acked[1], 20'hFFFFF);
      check("wrap_addr2", acked[2], 20'h00000);
      check("wrap_addr3", acked[3], 20'h00001);
    end
    check("wrap_disp_bank", disp_bank, 1'b0);
    tick();

    // Reset during WAIT aborts the fetch.
    ack_dly = 1; rv_dly = 3;
    n0 = acked.size();
    start_row(20'h05000, 11'd4);
    cnt = 0;
    while (acked.size() < n0 + 1 && cnt < 50) begin
      cnt++;
      tick();
    end
    reset = 1'b1;
    tick();
    check("mid_rst_mem_req", bus.mem_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_disp_bank", disp_bank, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    reset    = 1'b0;
    stray_rv = 1'b1;
    tick();
    stray_rv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | bus.buf_ce;
      tick();
    end
    check("mid_rst_no_write", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
